// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : RV32I fetch stage. Single-outstanding imem handshake, redirect and
//            flush squash, 1-entry skid buffer, NOP injection on bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int                   ADDR_LEN = 32,
    parameter int                   ISA_LEN  = 32,
    parameter logic [ADDR_LEN-1:0]  RESET_PC = '0,
    parameter logic [ISA_LEN-1:0]   NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                jmp_en,
    input  logic [ADDR_LEN-1:0] jmp_addr,
    output logic                imem_req_,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [ISA_LEN-1:0]  imem_rdata,
    output logic [ISA_LEN-1:0]  inst_o,
    output logic [ADDR_LEN-1:0] pc_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [ADDR_LEN-1:0] c_PC_STEP  = ADDR_LEN'(4);
    localparam logic [ADDR_LEN-1:0] c_RESET_PC = {RESET_PC[ADDR_LEN-1:2], 2'b00};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_LEN-1:0]   r_fetch_pc;
    logic [ADDR_LEN-1:0]   r_req_pc;
    logic                  r_buf_v;
    logic [ISA_LEN-1:0]    r_buf_inst;
    logic [ADDR_LEN-1:0]   r_buf_pc;
    logic                  r_kill;
    logic [ISA_LEN-1:0]    r_inst;
    logic [ADDR_LEN-1:0]   r_pc;

    logic                  w_req;
    logic                  w_grant;
    logic                  w_resp;
    logic                  w_squash;
    logic                  w_take;
    logic                  w_unused_jmp_lsb;

    assign w_unused_jmp_lsb = ^jmp_addr[1:0];

    // Request is masked during reset so the first one appears only once rst is low.
    always_comb begin
        w_req       = (r_state == S_IDLE) && !r_buf_v && !rst;
        w_grant     = w_req && imem_gnt;
        w_resp      = (r_state == S_WAIT) && imem_rvalid;
        w_squash    = jmp_en || flush;
        w_take      = w_resp && !r_kill && !w_squash;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_WAIT;
            S_WAIT:  if (imem_rvalid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign imem_req_ = ~w_req;
    assign imem_addr = r_fetch_pc;
    assign inst_o    = r_inst;
    assign pc_o      = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= c_RESET_PC;
            r_req_pc   <= c_RESET_PC;
            r_kill     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_req_pc <= r_fetch_pc;
            if (jmp_en)
                r_fetch_pc <= {jmp_addr[ADDR_LEN-1:2], 2'b00};
            else if (w_grant)
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            // A squash coinciding with the response retires that request, so
            // only a request still in flight after this edge is marked dead.
            if (w_squash && (w_grant || (r_state == S_WAIT && !imem_rvalid)))
                r_kill <= 1'b1;
            else if (w_resp)
                r_kill <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst     <= NOP_INST;
            r_pc       <= RESET_PC;
            r_buf_v    <= 1'b0;
            r_buf_inst <= NOP_INST;
            r_buf_pc   <= c_RESET_PC;
        end else if (w_squash) begin
            r_inst  <= NOP_INST;
            r_buf_v <= 1'b0;
        end else if (w_take) begin
            if (!stall) begin
                r_inst <= imem_rdata;
                r_pc   <= r_req_pc;
            end else begin
                r_buf_inst <= imem_rdata;
                r_buf_pc   <= r_req_pc;
                r_buf_v    <= 1'b1;
            end
        end else if (!stall) begin
            if (r_buf_v) begin
                r_inst  <= r_buf_inst;
                r_pc    <= r_buf_pc;
                r_buf_v <= 1'b0;
            end else begin
                r_inst <= NOP_INST;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Randomized bench for ifu_fetch against a queue-based fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam logic [31:0] c_RPC = 32'h0000_0000;
    localparam int          c_CYCLES = 4000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic        imem_req_;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    ifu_fetch #(
        .ADDR_LEN (32),
        .ISA_LEN  (32),
        .RESET_PC (c_RPC),
        .NOP_INST (c_NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .imem_req_   (imem_req_),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_o      (inst_o),
        .pc_o        (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed hash of the address, never a NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] v;
        v = (a * 32'h9E37_79B1) ^ 32'h1234_5670;
        if (v == c_NOP) v = v ^ 32'h1;
        return v;
    endfunction

    // Fetch model: what decode sees, the pending imem transaction, and
    // responses parked while decode is stalled.
    logic [31:0] m_fetch_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    bit          m_out_v;
    bit          m_out_dead;
    logic [31:0] m_out_pc;
    ent_t        m_held[$];
    logic [31:0] mem_addr;

    task automatic model_reset();
        m_fetch_pc = c_RPC;
        m_inst     = c_NOP;
        m_pc       = c_RPC;
        m_out_v    = 1'b0;
        m_out_dead = 1'b0;
        m_held.delete();
    endtask

    function automatic bit m_req();
        return !m_out_v && (m_held.size() == 0);
    endfunction

    task automatic model_step();
        bit   grant;
        bit   resp;
        bit   sq;
        ent_t e;
        grant = m_req() && imem_gnt;
        resp  = m_out_v && imem_rvalid;
        sq    = flush || jmp_en;
        if (sq) begin
            m_inst = c_NOP;
            m_held.delete();
        end else if (resp && !m_out_dead) begin
            e.inst = mem_word(m_out_pc);
            e.pc   = m_out_pc;
            if (stall) m_held.push_back(e);
            else begin
                m_inst = e.inst;
                m_pc   = e.pc;
            end
        end else if (!stall) begin
            if (m_held.size() > 0) begin
                e      = m_held.pop_front();
                m_inst = e.inst;
                m_pc   = e.pc;
            end else begin
                m_inst = c_NOP;
            end
        end
        if (resp) m_out_v = 1'b0;
        else if (m_out_v && sq) m_out_dead = 1'b1;
        if (grant) begin
            m_out_v    = 1'b1;
            m_out_pc   = m_fetch_pc;
            m_out_dead = sq;
        end
        if (jmp_en) m_fetch_pc = {jmp_addr[31:2], 2'b00};
        else if (grant) m_fetch_pc = m_fetch_pc + 32'd4;
    endtask

    task automatic drive_idle();
        stall       = 1'b0;
        flush       = 1'b0;
        jmp_en      = 1'b0;
        jmp_addr    = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    initial begin
        bit did_mid_reset;
        did_mid_reset = 1'b0;
        rst = 1'b1;
        drive_idle();
        mem_addr = '0;
        model_reset();
        #12;
        check("reset_inst", inst_o, c_NOP);
        check("reset_pc", pc_o, c_RPC);
        check("reset_req", {31'd0, imem_req_}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < c_CYCLES; i++) begin
            if (!did_mid_reset && i >= c_CYCLES / 2 && m_out_v) begin
                did_mid_reset = 1'b1;
                drive_idle();
                #2 rst = 1'b1;
                #1;
                check("async_rst_inst", inst_o, c_NOP);
                check("async_rst_pc", pc_o, c_RPC);
                check("async_rst_req", {31'd0, imem_req_}, 32'd1);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(mem_addr);
                    #1;
                    check("rst_hold_inst", inst_o, c_NOP);
                    check("rst_hold_req", {31'd0, imem_req_}, 32'd1);
                end
                @(negedge clk);
                drive_idle();
                rst = 1'b0;
                model_reset();
            end

            check("inst_o", inst_o, m_inst);
            check("pc_o", pc_o, m_pc);

            stall  = ($urandom_range(0, 99) < 30);
            flush  = ($urandom_range(0, 99) < 4);
            jmp_en = ($urandom_range(0, 99) < 7);
            if ($urandom_range(0, 9) == 0)
                jmp_addr = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            else
                jmp_addr = $urandom;
            imem_gnt    = ($urandom_range(0, 99) < 60);
            imem_rvalid = m_out_v && ($urandom_range(0, 1) == 1);
            imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;

            #1;
            check("imem_req_", {31'd0, imem_req_}, {31'd0, !m_req()});
            if (m_req()) begin
                check("imem_addr", imem_addr, m_fetch_pc);
                if (imem_gnt) mem_addr = imem_addr;
            end

            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        if (!did_mid_reset) begin
            n_tests++;
            n_fail++;
            $display("FAIL mid_reset: got not-exercised, expected exercised");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage of the 5-stage RV32I core. Sits directly upstream of the decode stage and feeds it `inst_o` / `pc_o`.
- Owns the fetch PC and runs a single-outstanding request/grant/response handshake to instruction memory.
- Applies jump redirects and flushes. Holds its output under stall, using a 1-entry skid buffer.
- Inserts a NOP (`addi x0,x0,0` = 32'h0000_0013) on every bubble, so decode never sees undefined data.

Parameters:
- `ADDR_LEN`, 32, PC/address width.
- `ISA_LEN`, 32, instruction width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INST`, 32'h0000_0013, instruction injected on bubbles.

Ports:
- `clk` input 1: core clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: from ctrl; hold the decode-facing outputs.
- `flush` input 1: from ctrl; squash the output register, the skid buffer and any in-flight response.
- `jmp_en` input 1: redirect request from BPU/EXU.
- `jmp_addr` input `ADDR_LEN`: redirect target.
- `imem_req_` output 1: active-low fetch request.
- `imem_addr` output `ADDR_LEN`: fetch address, word aligned.
- `imem_gnt` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: response data valid.
- `imem_rdata` input `ISA_LEN`: fetched instruction.
- `inst_o` output `ISA_LEN`: instruction to decode.
- `pc_o` output `ADDR_LEN`: PC of `inst_o`.

Behaviour:
- Reset (async, any cycle including mid-transaction):
  - `inst_o` = `NOP_INST`, `pc_o` = `RESET_PC`, `imem_req_` = 1.
  - `fetch_pc` = `RESET_PC`, state = IDLE, skid buffer empty, kill = 0.
- First request appears the first cycle after `rst` falls.
- Registers:
  - `fetch_pc`: address of the next request.
  - `req_pc`: PC of the outstanding request.
  - skid buffer: `buf_v`, `buf_inst`, `buf_pc`.
  - kill flag.
- FSM, two states:
  - IDLE: `imem_req_` = 0 iff `buf_v` = 0; `imem_addr` = `fetch_pc`. On `imem_gnt` (with `imem_req_` = 0): `req_pc` <= `fetch_pc`, `fetch_pc` <= `fetch_pc` + 4 (wraps mod 2^32), go to WAIT. The request stays asserted with a stable address until granted.
  - WAIT: `imem_req_` = 1. On `imem_rvalid`: clear kill, go to IDLE. A new request is issued at the earliest the cycle after `rvalid`, so latency is at least 2 cycles per fetch.
- Response routing (`rvalid` in WAIT):
  - kill = 1, or `flush`/`jmp_en` in the same cycle: data is discarded.
  - else `stall` = 0: `inst_o` <= `imem_rdata`, `pc_o` <= `req_pc`.
  - else (stall = 1): `buf_inst` <= `imem_rdata`, `buf_pc` <= `req_pc`, `buf_v` <= 1.
- Output register update when no response is being consumed:
  - `stall` = 1: hold `inst_o` / `pc_o`.
  - `stall` = 0 and `buf_v`: output the buffer contents, `buf_v` <= 0.
  - `stall` = 0 otherwise: `inst_o` <= `NOP_INST`, `pc_o` holds.
- Redirect (`jmp_en` = 1): honoured regardless of `stall`.
  - `fetch_pc` <= {`jmp_addr[31:2]`, 2'b00}. This overrides the +4 of a same-cycle grant.
  - `inst_o` <= `NOP_INST`; `pc_o` holds; `buf_v` <= 0.
  - If state is WAIT, or a grant occurs this cycle, kill <= 1.
- `flush` alone: same squash as a redirect (output NOP, `buf_v` <= 0, kill an in-flight request), but `fetch_pc` is not changed.
- Priority: `rst` > (`jmp_en` | `flush`) > `stall` > normal flow.
- Killed request: the FSM stays in WAIT until its `rvalid` arrives. No new request is issued before then.
- A repeat `jmp_en` while kill is already set only updates `fetch_pc`.
- `imem_addr[1:0]` is always 2'b00.
- At most one request is outstanding at any time. The skid buffer never overflows, because no request is issued while `buf_v` = 1.

Test Plan:
1. Reset release, memory returns grant same cycle and `rvalid` next cycle with 0x00500093 / 0x00100113: `imem_addr` = 0x0 then 0x4; `inst_o` = 0x00500093 with `pc_o` = 0x0, then 0x00100113 with `pc_o` = 0x4, with a NOP bubble between them.
2. `stall` held 3 cycles while the response 0x00208133 for PC 0x8 arrives: outputs unchanged, `buf_v` = 1, `imem_req_` stays 1. After stall drops, `inst_o` = 0x00208133, `pc_o` = 0x8 on the next edge.
3. `jmp_en` with `jmp_addr` = 0x102 while in WAIT for PC 0xC: the returning data is discarded; the next request has `imem_addr` = 0x100; `inst_o` = NOP until the 0x100 response arrives.
4. `jmp_en` to 0x40 in the same cycle as a grant for 0x10: `fetch_pc` = 0x40, not 0x14; the 0x10 response is dropped; the next `imem_addr` = 0x40.
5. `flush` with `buf_v` = 1 during stall: `buf_v` -> 0; `inst_o` = NOP; fetch resumes at the unchanged `fetch_pc`.
6. `rst` asserted while in WAIT, with a late `rvalid` arriving during reset: all outputs return to reset values asynchronously; first request after release is to `RESET_PC`; the stale response is never presented.
